// File: rtl/i3c_pkg.sv
// Shared types and constants for the I3C pad-side I/O controller.
//  io_mode_e      per-bus driver mode: open-drain, push-pull, PP->OD handoff
//  SyncStagesMin  minimum input synchroniser depth
//  clog2_min1     counter width helper that never returns 0
package i3c_pkg;

    typedef enum logic [1:0] {IoOd, IoPp, IoHandoff} io_mode_e;

    localparam int unsigned SyncStagesMin = 2;

    // Bits needed to hold values 0..v-1, at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/i3c_io_line.sv
// One pad input line: synchroniser plus optional spike filter.
//  clk_i   in  clock
//  rst_ni  in  asynchronous active-low reset (line resets to 1)
//  pad_i   in  raw pad level
//  line_o  out synchronised (and, with I3C_SPIKE_FILTER_EN, filtered) level
// Build option: I3C_SPIKE_FILTER_EN adds the FilterCycles stability filter.
module i3c_io_line
    import i3c_pkg::*;
#(
    parameter int unsigned SyncStages   = 2,
    parameter int unsigned FilterCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    output logic line_o
);

    // Depths below the minimum are raised to it rather than rejected.
    localparam int unsigned Stages = (SyncStages < SyncStagesMin) ? SyncStagesMin : SyncStages;

    logic [Stages-1:0] sync_q;
    logic [Stages-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[Stages-2:0], pad_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef I3C_SPIKE_FILTER_EN
    localparam int unsigned FiltCyc = (FilterCycles < 1) ? 1 : FilterCycles;
    localparam int unsigned CntW    = clog2_min1(FiltCyc);

    logic            filt_q;
    logic            filt_d;
    logic [CntW-1:0] fcnt_q;
    logic [CntW-1:0] fcnt_d;

    // The output flips on the FiltCyc-th consecutive disagreeing sample;
    // any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[Stages-1] != filt_q) begin
            if (fcnt_q == CntW'(FiltCyc - 1)) begin
                filt_d = sync_q[Stages-1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign line_o = filt_q;
`else
    assign line_o = sync_q[Stages-1];
`endif

endmodule

// File: rtl/i3c_bus_io_ctrl.sv
// Multi-bus I3C pad controller: registered OD/PP sequencer per bus between the
// I3C core PHY signals and the SCL/SDA pad cells.
//  clk_i, rst_ni                 clock, asynchronous active-low reset
//  enable_i, sel_od_pp_i         per-bus driver enable, 1 = push-pull requested
//  scl_core_i, sda_core_i        levels the core wants on the bus
//  scl_core_o, sda_core_o        synchronised (filtered) pad levels to the core
//  scl_pad_i, sda_pad_i          raw pad levels
//  scl/sda_pad_o, *_pad_oe_o     registered pad value / output enable
//  idle_cycles_i                 bus-free threshold shared by all buses
//  bus_idle_o                    SCL and SDA high for >= idle_cycles_i cycles
//  pp_active_o                   bus is in push-pull or handoff
// Build option: I3C_SPIKE_FILTER_EN enables the input spike filter.
module i3c_bus_io_ctrl
    import i3c_pkg::*;
#(
    parameter int unsigned NumBuses      = 1,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned FilterCycles  = 4,
    parameter int unsigned HandoffCycles = 2,
    parameter int unsigned IdleCntW      = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumBuses-1:0] enable_i,
    input  logic [NumBuses-1:0] sel_od_pp_i,
    input  logic [NumBuses-1:0] scl_core_i,
    input  logic [NumBuses-1:0] sda_core_i,
    output logic [NumBuses-1:0] scl_core_o,
    output logic [NumBuses-1:0] sda_core_o,
    input  logic [NumBuses-1:0] scl_pad_i,
    input  logic [NumBuses-1:0] sda_pad_i,
    output logic [NumBuses-1:0] scl_pad_o,
    output logic [NumBuses-1:0] scl_pad_oe_o,
    output logic [NumBuses-1:0] sda_pad_o,
    output logic [NumBuses-1:0] sda_pad_oe_o,
    input  logic [IdleCntW-1:0] idle_cycles_i,
    output logic [NumBuses-1:0] bus_idle_o,
    output logic [NumBuses-1:0] pp_active_o
);

    localparam int unsigned HoCyc = (HandoffCycles < 1) ? 1 : HandoffCycles;
    localparam int unsigned HcW   = clog2_min1(HoCyc + 1);

    for (genvar b = 0; b < NumBuses; b++) begin : g_bus

        logic scl_line;
        logic sda_line;

        i3c_io_line #(
            .SyncStages  (SyncStages),
            .FilterCycles(FilterCycles)
        ) u_scl_line (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .pad_i (scl_pad_i[b]),
            .line_o(scl_line)
        );

        i3c_io_line #(
            .SyncStages  (SyncStages),
            .FilterCycles(FilterCycles)
        ) u_sda_line (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .pad_i (sda_pad_i[b]),
            .line_o(sda_line)
        );

        assign scl_core_o[b] = scl_line;
        assign sda_core_o[b] = sda_line;

        // ---------------- mode FSM ----------------
        io_mode_e           mode_q, mode_d;
        logic [HcW-1:0]     ho_cnt_q, ho_cnt_d;
        logic               scl_hold_q, scl_hold_d;
        logic               sda_hold_q, sda_hold_d;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mode_q     <= IoOd;
                ho_cnt_q   <= '0;
                scl_hold_q <= 1'b0;
                sda_hold_q <= 1'b0;
            end else begin
                mode_q     <= mode_d;
                ho_cnt_q   <= ho_cnt_d;
                scl_hold_q <= scl_hold_d;
                sda_hold_q <= sda_hold_d;
            end
        end

        // Pad registers; their current value is the "last driven" level
        // consulted when push-pull is released.
        logic scl_o_q, scl_o_d, scl_oe_q, scl_oe_d;
        logic sda_o_q, sda_o_d, sda_oe_q, sda_oe_d;

        always_comb begin
            mode_d     = mode_q;
            ho_cnt_d   = ho_cnt_q;
            scl_hold_d = scl_hold_q;
            sda_hold_d = sda_hold_q;
            if (!enable_i[b]) begin
                mode_d     = IoOd;
                ho_cnt_d   = '0;
                scl_hold_d = 1'b0;
                sda_hold_d = 1'b0;
            end else begin
                case (mode_q)
                    IoOd: begin
                        if (sel_od_pp_i[b]) begin
                            mode_d = IoPp;
                        end
                    end
                    IoPp: begin
                        if (!sel_od_pp_i[b]) begin
                            if (scl_o_q || sda_o_q) begin
                                mode_d     = IoHandoff;
                                ho_cnt_d   = HcW'(1);
                                scl_hold_d = scl_o_q;
                                sda_hold_d = sda_o_q;
                            end else begin
                                mode_d = IoOd;
                            end
                        end
                    end
                    IoHandoff: begin
                        if (sel_od_pp_i[b] || (ho_cnt_q >= HcW'(HoCyc))) begin
                            mode_d     = sel_od_pp_i[b] ? IoPp : IoOd;
                            ho_cnt_d   = '0;
                            scl_hold_d = 1'b0;
                            sda_hold_d = 1'b0;
                        end else begin
                            ho_cnt_d = ho_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        mode_d = IoOd;
                    end
                endcase
            end
        end

        // Pad values are derived from the next mode so a request reaches the
        // pad exactly one cycle later.
        always_comb begin
            scl_o_d  = 1'b0;
            scl_oe_d = enable_i[b] & ~scl_core_i[b];
            sda_o_d  = 1'b0;
            sda_oe_d = enable_i[b] & ~sda_core_i[b];
            case (mode_d)
                IoPp: begin
                    scl_o_d  = scl_core_i[b];
                    scl_oe_d = 1'b1;
                    sda_o_d  = sda_core_i[b];
                    sda_oe_d = 1'b1;
                end
                IoHandoff: begin
                    if (scl_hold_d) begin
                        scl_o_d  = 1'b1;
                        scl_oe_d = 1'b1;
                    end
                    if (sda_hold_d) begin
                        sda_o_d  = 1'b1;
                        sda_oe_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                scl_o_q  <= 1'b0;
                scl_oe_q <= 1'b0;
                sda_o_q  <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                scl_o_q  <= scl_o_d;
                scl_oe_q <= scl_oe_d;
                sda_o_q  <= sda_o_d;
                sda_oe_q <= sda_oe_d;
            end
        end

        assign scl_pad_o[b]    = scl_o_q;
        assign scl_pad_oe_o[b] = scl_oe_q;
        assign sda_pad_o[b]    = sda_o_q;
        assign sda_pad_oe_o[b] = sda_oe_q;
        assign pp_active_o[b]  = (mode_q != IoOd);

        // ---------------- bus-free detector ----------------
        logic [IdleCntW-1:0] idle_cnt_q, idle_cnt_d;
        logic                idle_q, idle_d;

        always_comb begin
            idle_cnt_d = '0;
            if (scl_line && sda_line) begin
                idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
            end
            // Compared against the updated count so a zero threshold tracks
            // the line levels with a single cycle of delay.
            idle_d = scl_line && sda_line && (idle_cnt_d >= idle_cycles_i);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                idle_cnt_q <= '0;
                idle_q     <= 1'b0;
            end else begin
                idle_cnt_q <= idle_cnt_d;
                idle_q     <= idle_d;
            end
        end

        assign bus_idle_o[b] = idle_q;

    end

endmodule
